// File: rtl/adder_share_pkg.sv
// Shared constants and width helpers for the shared-adder scheduler.
package adder_share_pkg;

  localparam int DEF_WIDTH   = 60;
  localparam int DEF_NUM_REQ = 4;

  // Tag width for n requesters; never below one bit.
  function automatic int id_width(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int sum_width(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after the last winner and
// owns the rotating pointer, which only moves when a grant is issued.
module adder_rr_arbiter
  import adder_share_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_gnt_idx,
  output logic               o_gnt_valid
);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_cand [NUM_REQ];
  logic [ID_W-1:0] w_idx;
  logic            w_found;

  // w_cand[k] is the requester index at scan offset k+1 from the pointer.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [ID_W:0] w_pos;
    assign w_pos       = {1'b0, r_ptr} + (ID_W + 1)'(gi + 1);
    assign w_cand[gi]  = (w_pos >= (ID_W + 1)'(NUM_REQ)) ?
                         ID_W'(w_pos - (ID_W + 1)'(NUM_REQ)) : ID_W'(w_pos);
  end

  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[w_cand[k]]) begin
        w_found = 1'b1;
        w_idx   = w_cand[k];
      end
    end
  end

  always_comb begin
    o_gnt_valid = i_en & w_found;
    o_gnt_idx   = w_idx;
    o_gnt       = '0;
    if (o_gnt_valid) o_gnt[w_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= ID_W'(NUM_REQ - 1);
    end else if (o_gnt_valid) begin
      r_ptr <= w_idx;
    end
  end

endmodule

// File: rtl/adder_share_sched.sv
// One registered adder shared by NUM_REQ requesters through a two-stage
// pipeline with backpressure. `ADDER_SHARE_SCHED_PERF_EN adds a grant counter.
module adder_share_sched
  import adder_share_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH:0]           rsp_sum,
  input  logic                     rsp_ready
`ifdef ADDER_SHARE_SCHED_PERF_EN
  ,
  output logic [31:0]              perf_grants
`endif
);

  localparam int SUM_W = sum_width(WIDTH);

  logic [WIDTH-1:0] w_a_arr [NUM_REQ];
  logic [WIDTH-1:0] w_b_arr [NUM_REQ];
  logic [ID_W-1:0]  w_gnt_idx;
  logic             w_gnt_valid;
  logic             w_hold1;
  logic             w_hold2;
  logic             w_arb_en;
  logic [SUM_W-1:0] w_sum;

  logic [WIDTH-1:0] r_a1;
  logic [WIDTH-1:0] r_b1;
  logic [ID_W-1:0]  r_id1;
  logic             r_v1;
  logic [SUM_W-1:0] r_sum2;
  logic [ID_W-1:0]  r_id2;
  logic             r_v2;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_operands
    assign w_a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
    assign w_b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
  end

  // S2 stalls on consumer backpressure; S1 stalls only if S2 cannot take it.
  assign w_hold2  = r_v2 & ~rsp_ready;
  assign w_hold1  = r_v1 & w_hold2;
  assign w_arb_en = ~w_hold1 & ~reset;

  adder_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .i_req       (req_valid),
    .i_en        (w_arb_en),
    .o_gnt       (req_ready),
    .o_gnt_idx   (w_gnt_idx),
    .o_gnt_valid (w_gnt_valid)
  );

  assign w_sum = {1'b0, r_a1} + {1'b0, r_b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1  <= 1'b0;
      r_a1  <= '0;
      r_b1  <= '0;
      r_id1 <= '0;
    end else if (!w_hold1) begin
      r_v1 <= w_gnt_valid;
      if (w_gnt_valid) begin
        r_a1  <= w_a_arr[w_gnt_idx];
        r_b1  <= w_b_arr[w_gnt_idx];
        r_id1 <= w_gnt_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v2   <= 1'b0;
      r_sum2 <= '0;
      r_id2  <= '0;
    end else if (!w_hold2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_sum2 <= w_sum;
        r_id2  <= r_id1;
      end
    end
  end

  assign rsp_valid = r_v2;
  assign rsp_id    = r_id2;
  assign rsp_sum   = r_sum2;

`ifdef ADDER_SHARE_SCHED_PERF_EN
  logic [31:0] r_perf_grants;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_grants <= '0;
    end else if (w_gnt_valid) begin
      r_perf_grants <= r_perf_grants + 32'd1;
    end
  end

  assign perf_grants = r_perf_grants;
`endif

endmodule

// File: tb/tb_adder_share_sched.sv
// Randomised and directed bench for adder_share_sched, checked against a
// queue-based model of round-robin grants and in-order tagged responses.
module tb_adder_share_sched;

  localparam int W = 60;
  localparam int N = 4;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [W:0]     rsp_sum;
  logic           rsp_ready;
`ifdef ADDER_SHARE_SCHED_PERF_EN
  logic [31:0]    perf_grants;
`endif

  adder_share_sched dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_ready (rsp_ready)
`ifdef ADDER_SHARE_SCHED_PERF_EN
    ,
    .perf_grants (perf_grants)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [W:0] sum;
    int         cyc;
  } op_t;

  op_t          q[$];
  int           last_g;
  int           cyc;
  int           perf_exp;
  int           n_checks;
  int           n_pass;
  logic         v [N];
  logic [W-1:0] a [N];
  logic [W-1:0] b [N];
  logic         g_done [N];
  logic [N-1:0] obs_ready;

  function automatic logic [W-1:0] rand_operand();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return '0;
      default: return r[W-1:0];
    endcase
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]      = v[i];
      req_a[i*W +: W]   = a[i];
      req_b[i*W +: W]   = b[i];
    end
  endtask

  // One clock cycle: compare DUT against the model, then advance the model.
  task automatic tick();
    logic [N-1:0] exp_ready;
    logic [W:0]   s;
    int           w;
    int           j;
    int           c0;
    bit           allowed;
    bit           exp_rv;
    drive();
    #1;
    allowed = !reset && !(q.size() == 2 && !rsp_ready);
    w = -1;
    for (int k = 1; k <= N; k++) begin
      j = (last_g + k) % N;
      if (w < 0 && v[j]) w = j;
    end
    exp_ready = '0;
    if (allowed && w >= 0) exp_ready[w] = 1'b1;
    n_checks++;
    if (req_ready === exp_ready) n_pass++;
    else $display("FAIL grant cyc=%0d got=%b expected=%b", cyc, req_ready, exp_ready);
    exp_rv = (q.size() > 0) && (cyc - q[0].cyc >= 2);
    n_checks++;
    if (rsp_valid === exp_rv) n_pass++;
    else $display("FAIL rsp_valid cyc=%0d got=%b expected=%b", cyc, rsp_valid, exp_rv);
    if (exp_rv) begin
      n_checks++;
      if (rsp_id === 2'(q[0].id) && rsp_sum === q[0].sum) n_pass++;
      else $display("FAIL rsp_data cyc=%0d got id=%0d sum=%h expected id=%0d sum=%h",
                    cyc, rsp_id, rsp_sum, q[0].id, q[0].sum);
    end
    obs_ready = req_ready;
    c0 = cyc;
    @(posedge clk);
    cyc++;
    if (reset) begin
      q.delete();
      last_g   = N - 1;
      perf_exp = 0;
    end else begin
      if (exp_rv && rsp_ready) begin
        $display("rsp cyc=%0d id=%0d sum=%h", c0, q[0].id, q[0].sum);
        void'(q.pop_front());
      end
      if (exp_ready != '0) begin
        s = {1'b0, a[w]} + {1'b0, b[w]};
        q.push_back('{w, s, c0});
        last_g    = w;
        perf_exp++;
        g_done[w] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic retire();
    for (int j = 0; j < N; j++) begin
      if (g_done[j]) begin
        v[j]      = 1'b0;
        g_done[j] = 1'b0;
      end
    end
  endtask

  task automatic refresh_random();
    for (int j = 0; j < N; j++) begin
      if (g_done[j]) begin
        g_done[j] = 1'b0;
        v[j]      = ($urandom_range(0, 1) == 1);
        a[j]      = rand_operand();
        b[j]      = rand_operand();
      end else if (!v[j] && $urandom_range(0, 2) == 0) begin
        v[j] = 1'b1;
        a[j] = rand_operand();
        b[j] = rand_operand();
      end
    end
  endtask

  task automatic clear_reqs();
    for (int j = 0; j < N; j++) begin
      v[j]      = 1'b0;
      g_done[j] = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    clear_reqs();
    rsp_ready = 1'b1;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic drain();
    clear_reqs();
    rsp_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    rsp_ready = 1'b1;
    for (int j = 0; j < N; j++) begin
      v[j] = 1'b1;
      a[j] = rand_operand();
      b[j] = rand_operand();
    end
    drive();
    @(posedge clk);
    #1;
    repeat (3) tick();
    n_checks++;
    if (rsp_valid === 1'b0 && rsp_id === 2'd0 && rsp_sum === '0) n_pass++;
    else $display("FAIL reset_outputs got valid=%b id=%0d sum=%h required 0/0/0",
                  rsp_valid, rsp_id, rsp_sum);
    clear_reqs();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_op();
    v[0] = 1'b1;
    a[0] = W'(5);
    b[0] = W'(7);
    drive();
    #1;
    n_checks++;
    if (req_ready === 4'b0001) n_pass++;
    else $display("FAIL single_grant got=%b required=0001", req_ready);
    tick();
    retire();
    n_checks++;
    if (rsp_valid === 1'b0) n_pass++;
    else $display("FAIL single_early got valid=%b required 0", rsp_valid);
    tick();
    n_checks++;
    if (rsp_valid === 1'b1 && rsp_id === 2'd0 && rsp_sum === 61'd12) n_pass++;
    else $display("FAIL single_rsp got valid=%b id=%0d sum=%0d required 1/0/12",
                  rsp_valid, rsp_id, rsp_sum);
    drain();
  endtask

  task automatic test_carry();
    logic [W-1:0] ta [2];
    logic [W-1:0] tb [2];
    logic [W:0]   ts [2];
    ta[0] = '1;  tb[0] = W'(1); ts[0] = 61'h1000_0000_0000_0000;
    ta[1] = '0;  tb[1] = '0;    ts[1] = '0;
    for (int t = 0; t < 2; t++) begin
      v[0] = 1'b1;
      a[0] = ta[t];
      b[0] = tb[t];
      tick();
      retire();
      tick();
      n_checks++;
      if (rsp_valid === 1'b1 && rsp_sum === ts[t]) n_pass++;
      else $display("FAIL carry_%0d got valid=%b sum=%h required 1/%h", t, rsp_valid, rsp_sum, ts[t]);
      tick();
    end
    drain();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_oh;
    pulse_reset();
    for (int j = 0; j < N; j++) begin
      v[j] = 1'b1;
      a[j] = rand_operand();
      b[j] = rand_operand();
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      exp_oh = '0;
      exp_oh[k % N] = 1'b1;
      n_checks++;
      if (obs_ready === exp_oh) n_pass++;
      else $display("FAIL rr_grant step=%0d got=%b required=%b", k, obs_ready, exp_oh);
      if (k >= 1) begin
        n_checks++;
        if (rsp_valid === 1'b1 && rsp_id === 2'((k - 1) % N)) n_pass++;
        else $display("FAIL rr_rsp_id step=%0d got valid=%b id=%0d required 1/%0d",
                      k, rsp_valid, rsp_id, (k - 1) % N);
      end
      for (int j = 0; j < N; j++) begin
        if (g_done[j]) begin
          g_done[j] = 1'b0;
          a[j] = rand_operand();
          b[j] = rand_operand();
        end
      end
    end
    drain();
  endtask

  task automatic test_back_to_back_stall();
    logic [W:0] snap0;
    logic [W:0] snap1;
    pulse_reset();
    for (int j = 0; j < 2; j++) begin
      v[j] = 1'b1;
      a[j] = rand_operand();
      b[j] = rand_operand();
    end
    snap0 = {1'b0, a[0]} + {1'b0, b[0]};
    snap1 = {1'b0, a[1]} + {1'b0, b[1]};
    tick();
    retire();
    tick();
    retire();
    for (int j = 2; j < N; j++) begin
      v[j] = 1'b1;
      a[j] = rand_operand();
      b[j] = rand_operand();
    end
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive();
      #1;
      n_checks++;
      if (req_ready === 4'b0000 && rsp_valid === 1'b1 && rsp_id === 2'd0 && rsp_sum === snap0)
        n_pass++;
      else $display("FAIL stall_hold step=%0d got ready=%b valid=%b id=%0d sum=%h required 0000/1/0/%h",
                    k, req_ready, rsp_valid, rsp_id, rsp_sum, snap0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    retire();
    n_checks++;
    if (rsp_valid === 1'b1 && rsp_id === 2'd1 && rsp_sum === snap1) n_pass++;
    else $display("FAIL stall_release got valid=%b id=%0d sum=%h required 1/1/%h",
                  rsp_valid, rsp_id, rsp_sum, snap1);
    repeat (3) begin
      tick();
      retire();
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    pulse_reset();
    v[1] = 1'b1; a[1] = rand_operand(); b[1] = rand_operand();
    tick();
    retire();
    v[2] = 1'b1; a[2] = rand_operand(); b[2] = rand_operand();
    tick();
    retire();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (rsp_valid === 1'b0) n_pass++;
    else $display("FAIL midflight_flush got valid=%b required 0", rsp_valid);
    v[0] = 1'b1; a[0] = rand_operand(); b[0] = rand_operand();
    v[3] = 1'b1; a[3] = rand_operand(); b[3] = rand_operand();
    drive();
    #1;
    n_checks++;
    if (req_ready === 4'b0001) n_pass++;
    else $display("FAIL midflight_ptr got=%b required=0001", req_ready);
    repeat (3) begin
      tick();
      retire();
    end
    drain();
  endtask

  task automatic test_random();
    pulse_reset();
    for (int k = 0; k < 400; k++) begin
      rsp_ready = ($urandom_range(0, 9) < 7);
      tick();
      refresh_random();
    end
    drain();
    repeat (4) tick();
  endtask

`ifdef ADDER_SHARE_SCHED_PERF_EN
  task automatic test_perf();
    int issued;
    int budget;
    pulse_reset();
    issued = 0;
    budget = 0;
    while (issued < 10 && budget < 500) begin
      if (!v[0]) begin
        v[0] = 1'b1;
        a[0] = rand_operand();
        b[0] = rand_operand();
      end
      rsp_ready = ($urandom_range(0, 1) == 1);
      tick();
      budget++;
      if (g_done[0]) begin
        issued++;
        retire();
      end
    end
    n_checks++;
    if (issued == 10) n_pass++;
    else $display("FAIL perf_budget got issued=%0d required 10", issued);
    rsp_ready = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (perf_grants === 32'd10) n_pass++;
    else $display("FAIL perf_count got=%0d required 10", perf_grants);
    drain();
  endtask
`endif

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    cyc       = 0;
    last_g    = N - 1;
    perf_exp  = 0;
    obs_ready = '0;
    reset     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    for (int j = 0; j < N; j++) begin
      v[j]      = 1'b0;
      a[j]      = '0;
      b[j]      = '0;
      g_done[j] = 1'b0;
    end
    test_reset();
    test_single_op();
    test_carry();
    test_round_robin();
    test_back_to_back_stall();
    test_reset_midflight();
    test_random();
`ifdef ADDER_SHARE_SCHED_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
